lcd_pixel_fifo: RTL

LCD_PIXEL_FIFO -- requirements
Module: lcd_pixel_fifo

---
 rtl/lcd_pixel_fifo.sv | 80 ++++++++
 1 files changed

// File: rtl/lcd_pixel_fifo.sv
// lcd_pixel_fifo: single-clock first-word-fall-through pixel FIFO between the LCD DMA and the pixel serializer.
// Ports:
//    clk          - shared clock for the DMA write side and the serializer read side
//    rst          - asynchronous active-low reset
//    lcden        - controller enable; gates pops and the DMA request
//    watermark    - DMA request threshold: 0 = 4 free entries, 1 = 8 free entries
//    flush        - synchronous clear of pointers, level and sticky flags
//    wr_en        - DMA write strobe; wr_data is the 32-bit word written
//    pull         - serializer pop strobe
//    data_in_fifo - head word, 0 when empty
//    empty/full   - level is 0 / level is DEPTH
//    level        - number of stored words
//    dma_req      - registered request for more data
//    underflow    - sticky: pull seen while empty
//    overflow     - sticky: write dropped because full
module lcd_pixel_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          lcden,
   input  logic          watermark,
   input  logic          flush,
   input  logic          wr_en,
   input  logic [31:0]   wr_data,
   input  logic          pull,
   output logic [31:0]   data_in_fifo,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   level,
   output logic          dma_req,
   output logic          underflow,
   output logic          overflow
);
   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr, r_wr_ptr;
   logic [AW:0]   r_level;
   logic          r_dma_req, r_underflow, r_overflow;
   logic          w_pop, w_push, w_dma_next;
   logic [AW:0]   w_level_next;
   logic [7:0]    w_free;
   always_comb begin
      empty        = r_level == '0;
      full         = r_level == (AW+1)'(DEPTH);
      w_pop        = pull & lcden & ~empty & ~flush;
      // a full FIFO can still take a word when the serializer frees a slot in the same cycle
      w_push       = wr_en & (~full | w_pop) & ~flush;
      w_level_next = flush ? '0 : r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      // free space is evaluated on the post-edge level so dma_req tracks the level it is registered with
      w_free       = 8'(DEPTH) - 8'(w_level_next);
      w_dma_next   = lcden & ~flush & (w_free >= (watermark ? 8'd8 : 8'd4));
      data_in_fifo = empty ? 32'h0 : r_mem[r_rd_ptr];
      level        = r_level;
      dma_req      = r_dma_req;
      underflow    = r_underflow;
      overflow     = r_overflow;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_level     <= '0;
         r_dma_req   <= 1'b0;
         r_underflow <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_rd_ptr    <= flush ? '0 : r_rd_ptr + AW'(w_pop);
         r_wr_ptr    <= flush ? '0 : r_wr_ptr + AW'(w_push);
         r_level     <= w_level_next;
         r_dma_req   <= w_dma_next;
         r_underflow <= ~flush & (r_underflow | (pull & lcden & empty));
         r_overflow  <= ~flush & (r_overflow | (wr_en & full & ~w_pop));
      end
   end
   // storage is never cleared; reset and flush only move the pointers
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= wr_data;
   end
endmodule
